// File: rtl/ext_code_responder_if.sv
// ----------------------------------------------------------------------------
// ext_code_responder_if
//   Code-fetch bus between an MCU (EA low) and an external program memory.
//
//   Signals
//     ale     MCU -> mem  address latch enable, active high
//     psen_n  MCU -> mem  program store enable, active low
//     p0_in   MCU -> mem  P0 pad value (low address byte while ale is high)
//     p2_in   MCU -> mem  P2 pad value (high address byte)
//     p0_out  mem -> MCU  code byte driven onto P0
//     p0_oe   mem -> MCU  P0 drive enable (pad is tristated when low)
//
//   Handshake (this bus has no valid/ready pair, the strobes play that role):
//     An address is offered while ale=1 and is accepted on the falling edge
//     of ale. A read is requested by psen_n=0 and stays requested until
//     psen_n returns high. The responder answers by raising p0_oe with the
//     data and keeps it stable until the request is withdrawn. A new request
//     is only legal after a new ale fall.
//
//   Modports
//     master  the MCU side (drives strobes and address pads)
//     slave   the memory side (drives p0_out / p0_oe)
// ----------------------------------------------------------------------------
interface ext_code_responder_if;
    logic       ale;
    logic       psen_n;
    logic [7:0] p0_in;
    logic [7:0] p2_in;
    logic [7:0] p0_out;
    logic       p0_oe;

    modport master (
        output ale, psen_n, p0_in, p2_in,
        input  p0_out, p0_oe
    );

    modport slave (
        input  ale, psen_n, p0_in, p2_in,
        output p0_out, p0_oe
    );
endinterface

// File: rtl/ext_code_responder.sv
// ----------------------------------------------------------------------------
// ext_code_responder
//   External program-memory responder sitting on the far end of an MCU
//   ALE/PSEN/P0/P2 code-fetch bus. The 16-bit fetch address is demuxed from
//   P2/P0 on the ALE fall; while PSEN is low the addressed code byte is driven
//   onto P0 after ACCESS_LAT clocks. The code array is loaded through a simple
//   program port and is not cleared by reset.
//
//   Parameters
//     ADDR_W      implemented code-array address bits (DEPTH = 2**ADDR_W, <=16)
//     ACCESS_LAT  clocks from PSEN-low detect to P0 drive (>=1)
//     BLANK       byte returned for out-of-range or never-written addresses
//
//   Ports
//     clk         system clock (same as MCU clock)
//     reset       asynchronous, active-low reset
//     bus         code-fetch bus, slave side (ale, psen_n, p0_in, p2_in,
//                 p0_out, p0_oe)
//     prog_we     program-port write strobe
//     prog_addr   program-port address (ignored when >= DEPTH)
//     prog_data   program-port data
//     fetch_addr  last latched fetch address
//     fetch_cnt   completed fetches, wraps 16'hFFFF -> 0
//     proto_err   sticky: PSEN low seen with no latched address
//     state_dbg   current FSM state (0 IDLE, 1 WAIT, 2 DRIVE)
// ----------------------------------------------------------------------------
module ext_code_responder #(
    parameter int          ADDR_W     = 16,
    parameter int          ACCESS_LAT = 1,
    parameter logic [7:0]  BLANK      = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    ext_code_responder_if.slave  bus,
    input  logic                 prog_we,
    input  logic [15:0]          prog_addr,
    input  logic [7:0]           prog_data,
    output logic [15:0]          fetch_addr,
    output logic [15:0]          fetch_cnt,
    output logic                 proto_err,
    output logic [1:0]           state_dbg
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ale_q, ale_d;
    logic [7:0]       lo_shadow_q, lo_shadow_d;
    logic [7:0]       hi_shadow_q, hi_shadow_d;
    logic [15:0]      fetch_addr_q, fetch_addr_d;
    logic             addr_valid_q, addr_valid_d;
    logic [7:0]       p0_out_q, p0_out_d;
    logic             p0_oe_q, p0_oe_d;
    logic [15:0]      fetch_cnt_q, fetch_cnt_d;
    logic             proto_err_q, proto_err_d;

    // ------------------------------------------------------------------
    // Code array. A per-entry written flag lets never-written locations
    // read back as BLANK. Neither array is touched by reset.
    // ------------------------------------------------------------------
    logic [7:0] mem_q     [DEPTH];
    logic       written_q [DEPTH];

    logic              prog_hit;
    logic [ADDR_W-1:0] prog_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_in_range;
    logic [7:0]        rd_byte;

    assign prog_hit = prog_we && ((prog_addr >> ADDR_W) == 16'd0);
    assign prog_idx = prog_addr[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (prog_hit) begin
            mem_q[prog_idx]     <= prog_data;
            written_q[prog_idx] <= 1'b1;
        end
    end

    // The read is sampled by p0_out_q on the same edge a program write
    // lands, so a simultaneous write to the fetched address returns old data.
    assign rd_idx      = fetch_addr_q[ADDR_W-1:0];
    assign rd_in_range = ((fetch_addr_q >> ADDR_W) == 16'd0);
    assign rd_byte     = (rd_in_range && written_q[rd_idx]) ? mem_q[rd_idx] : BLANK;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ale_q        <= 1'b0;
            lo_shadow_q  <= 8'h00;
            hi_shadow_q  <= 8'h00;
            fetch_addr_q <= 16'h0000;
            addr_valid_q <= 1'b0;
            p0_out_q     <= 8'h00;
            p0_oe_q      <= 1'b0;
            fetch_cnt_q  <= 16'h0000;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ale_q        <= ale_d;
            lo_shadow_q  <= lo_shadow_d;
            hi_shadow_q  <= hi_shadow_d;
            fetch_addr_q <= fetch_addr_d;
            addr_valid_q <= addr_valid_d;
            p0_out_q     <= p0_out_d;
            p0_oe_q      <= p0_oe_d;
            fetch_cnt_q  <= fetch_cnt_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ale_d        = bus.ale;
        lo_shadow_d  = lo_shadow_q;
        hi_shadow_d  = hi_shadow_q;
        fetch_addr_d = fetch_addr_q;
        addr_valid_d = addr_valid_q;
        p0_out_d     = p0_out_q;
        p0_oe_d      = p0_oe_q;
        fetch_cnt_d  = fetch_cnt_q;
        proto_err_d  = proto_err_q;

        // Address pads are tracked for as long as ale is high; the value
        // from the last ale-high cycle is the one that gets latched.
        if (bus.ale) begin
            lo_shadow_d = bus.p0_in;
            hi_shadow_d = bus.p2_in;
        end

        case (state_q)
            S_IDLE: begin
                if (!bus.psen_n) begin
                    if (addr_valid_q) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                // ale high means the MCU has moved on; abandon the access.
                if (bus.ale || bus.psen_n) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    p0_out_d = rd_byte;
                    p0_oe_d  = 1'b1;
                    state_d  = S_DRIVE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DRIVE: begin
                if (bus.ale) begin
                    // Contention guard: release P0 without counting a fetch.
                    p0_oe_d = 1'b0;
                    state_d = S_IDLE;
                end else if (bus.psen_n) begin
                    p0_oe_d      = 1'b0;
                    fetch_cnt_d  = fetch_cnt_q + 16'd1;
                    addr_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                p0_oe_d = 1'b0;
            end
        endcase

        // A fresh ALE fall always re-arms the address, even if the same
        // edge also retires a fetch.
        if (ale_q && !bus.ale) begin
            fetch_addr_d = {hi_shadow_q, lo_shadow_q};
            addr_valid_d = 1'b1;
        end
    end

    assign bus.p0_out = p0_out_q;
    assign bus.p0_oe  = p0_oe_q;
    assign fetch_addr = fetch_addr_q;
    assign fetch_cnt  = fetch_cnt_q;
    assign proto_err  = proto_err_q;
    assign state_dbg  = state_q;

endmodule
